// File: rtl/des_key_sched_if.sv
// rtl/des_key_sched_if.sv - key-in / subkey-out handshake bundle for des_key_sched
//
// Purpose: groups the key acceptance handshake, the subkey stream handshake
// and the status flags of the DES key scheduler into one interface.
// Signals:
//   key_valid    key_in and decrypt are valid (master -> slave)
//   key_ready    scheduler can accept a key (slave -> master)
//   key_in       64-bit DES key, key_in[63] is FIPS bit 1
//   decrypt      0 = emit K1..K16, 1 = emit K16..K1
//   subkey_valid subkey and subkey_round are valid (slave -> master)
//   subkey_ready consumer accepts the subkey (master -> slave)
//   subkey       48-bit PC-2 subkey, subkey[47] is FIPS bit 1
//   subkey_round 0-based index of the emitted subkey
//   done         pulses on the 16th subkey handshake
//   parity_err   key odd-parity violation flag
// Modports: master = key source / subkey consumer, slave = the scheduler.

interface des_key_sched_if;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key_in;
    logic        decrypt;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [3:0]  subkey_round;
    logic        done;
    logic        parity_err;

    modport master (
        output key_valid, key_in, decrypt, subkey_ready,
        input  key_ready, subkey_valid, subkey, subkey_round, done, parity_err
    );

    modport slave (
        input  key_valid, key_in, decrypt, subkey_ready,
        output key_ready, subkey_valid, subkey, subkey_round, done, parity_err
    );
endinterface

// File: rtl/des_key_sched.sv
// rtl/des_key_sched.sv - sequential DES key schedule, one PC-2 subkey per beat
//
// Purpose: accepts a 64-bit key, applies PC-1, then walks the C/D halves
// through the 16 rounds and emits one registered 48-bit subkey per handshake.
// Encryption emits K1..K16 using left rotations, decryption emits K16..K1
// using right rotations.
// Parameters:
//   NO_BP  1 = subkey_ready ignored and treated as always 1
// Optional feature (macro DES_KEY_PARITY_CHK_EN): when defined, parity_err
// is set on key accept if any key byte has even parity; when undefined,
// parity_err is tied to 0.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  des_key_sched_if.slave: key handshake, subkey handshake, done,
//        parity_err

module des_key_sched #(
    parameter bit NO_BP = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    des_key_sched_if.slave  bus
);

    // FIPS PC-1 and PC-2 selection tables, 1-based bit numbers
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // cd[55] holds FIPS C bit 1; C = cd[55:28], D = cd[27:0]
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
        end
        return cd;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] sk;
        sk = '0;
        for (int i = 0; i < 48; i++) begin
            sk[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
        end
        return sk;
    endfunction

    // Rounds 1, 2, 9 and 16 shift by one, all others by two
    function automatic logic shift_two(input logic [4:0] r);
        return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
    endfunction

    // Rotation toward FIPS bit 1 (the MSB of each 28-bit half)
    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic [27:0] c_nxt;
    logic [27:0] d_nxt;
    logic        dir_q;
    logic [4:0]  n_q;
    logic        key_ready_q;
    logic        subkey_valid_q;
    logic [47:0] subkey_q;
    logic [3:0]  round_q;
    logic        accept;
    logic        hs;
    logic        last_beat;
    logic        load;
    logic        two;
    logic [55:0] cd0;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        hs        = 1'b0;
        last_beat = 1'b0;
        load      = 1'b0;
        c_nxt     = c_q;
        d_nxt     = d_q;
        two       = 1'b0;
        cd0       = pc1(bus.key_in);
        case (state)
            IDLE: begin
                if (bus.key_valid && key_ready_q) begin
                    accept    = 1'b1;
                    load      = 1'b1;
                    state_nxt = RUN;
                    // Decrypt starts from C0/D0 since C16 == C0
                    if (bus.decrypt) begin
                        c_nxt = cd0[55:28];
                        d_nxt = cd0[27:0];
                    end else begin
                        c_nxt = rotl28(cd0[55:28], 1'b0);
                        d_nxt = rotl28(cd0[27:0], 1'b0);
                    end
                end
            end
            RUN: begin
                hs = subkey_valid_q && (bus.subkey_ready || NO_BP);
                if (hs) begin
                    if (n_q == 5'd16) begin
                        last_beat = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        load = 1'b1;
                        // Next beat n+1: encrypt undoes nothing, it applies
                        // s(n+1); decrypt undoes s(17-n)
                        if (dir_q) begin
                            two   = shift_two(5'd17 - n_q);
                            c_nxt = rotr28(c_q, two);
                            d_nxt = rotr28(d_q, two);
                        end else begin
                            two   = shift_two(n_q + 5'd1);
                            c_nxt = rotl28(c_q, two);
                            d_nxt = rotl28(d_q, two);
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            key_ready_q    <= 1'b0;
            subkey_valid_q <= 1'b0;
            c_q            <= '0;
            d_q            <= '0;
            dir_q          <= 1'b0;
            n_q            <= '0;
            subkey_q       <= '0;
            round_q        <= '0;
        end else begin
            state          <= state_nxt;
            key_ready_q    <= (state_nxt == IDLE);
            subkey_valid_q <= (state_nxt == RUN);
            if (load) begin
                c_q      <= c_nxt;
                d_q      <= d_nxt;
                subkey_q <= pc2({c_nxt, d_nxt});
            end
            if (accept) begin
                dir_q   <= bus.decrypt;
                n_q     <= 5'd1;
                round_q <= bus.decrypt ? 4'd15 : 4'd0;
            end else if (load) begin
                n_q     <= n_q + 5'd1;
                round_q <= dir_q ? round_q - 4'd1 : round_q + 4'd1;
            end
        end
    end

`ifdef DES_KEY_PARITY_CHK_EN
    // A byte is in error when its XOR over all eight bits is 0 (even parity)
    function automatic logic parity_bad(input logic [63:0] k);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            bad = bad | ~(^k[b*8 +: 8]);
        end
        return bad;
    endfunction

    logic parity_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else if (accept) begin
            parity_err_q <= parity_bad(bus.key_in);
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.key_ready    = key_ready_q;
    assign bus.subkey_valid = subkey_valid_q;
    assign bus.subkey       = subkey_q;
    assign bus.subkey_round = round_q;
    assign bus.done         = last_beat;

endmodule

// File: tb/tb_des_key_sched.sv
// tb/tb_des_key_sched.sv - scoreboard bench for des_key_sched

module tb_des_key_sched;

    localparam logic [63:0] KEY1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY1P = 64'h133457799BBCDFF0;
    localparam logic [63:0] KEY2  = 64'h0123456789ABCDEF;

    // Published K1..K16 for KEY1
    localparam logic [47:0] K_TAB [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    localparam int M_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int M_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int M_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

`ifdef DES_KEY_PARITY_CHK_EN
    localparam logic EXP_PAR_BAD = 1'b1;
`else
    localparam logic EXP_PAR_BAD = 1'b0;
`endif

    typedef struct {
        logic [47:0] sk;
        logic [3:0]  rnd;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    des_key_sched_if bus ();

    des_key_sched #(.NO_BP(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb [$];
    exp_t        e_mon;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_done  = 0;
    logic        stalled = 1'b0;
    logic [47:0] hold_sk;
    logic [3:0]  hold_rnd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_tests++;
        n_fail++;
        $error("FAIL %s: observed timeout/extra beat expected clean completion", tag);
    endtask

    // Subkey r (1..16) by cumulative rotation of PC-1 halves
    function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int r);
        logic [27:0] c, d, cr, dr;
        logic [55:0] cd;
        logic [47:0] k;
        int          tot;
        c = '0; d = '0; k = '0; tot = 0;
        for (int i = 0; i < 28; i++) begin
            c = {c[26:0], key[6'(64 - M_PC1[i])]};
            d = {d[26:0], key[6'(64 - M_PC1[i + 28])]};
        end
        for (int j = 0; j < r; j++) tot += M_SHIFT[j];
        tot = tot % 28;
        cr = (c << tot) | (c >> (28 - tot));
        dr = (d << tot) | (d >> (28 - tot));
        if (tot == 0) begin cr = c; dr = d; end
        cd = {cr, dr};
        for (int i = 0; i < 48; i++) k = {k[46:0], cd[6'(56 - M_PC2[i])]};
        return k;
    endfunction

    function automatic logic [47:0] exp_k(input logic [63:0] key, input int r);
        if (key[63:1] == KEY1[63:1]) return K_TAB[r - 1];
        return ref_subkey(key, r);
    endfunction

    task automatic push_run(input logic [63:0] key, input logic dec);
        exp_t e;
        for (int b = 1; b <= 16; b++) begin
            int r;
            r      = dec ? 17 - b : b;
            e.sk   = exp_k(key, r);
            e.rnd  = 4'(r - 1);
            e.last = (b == 16);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns 1 ns after the accepting edge
    task automatic send_key(input logic [63:0] key, input logic dec);
        int   b;
        logic ok;
        bus.key_in    = key;
        bus.decrypt   = dec;
        bus.key_valid = 1'b1;
        b = 0;
        do begin
            ok = bus.key_ready;
            tick();
            b++;
        end while (!ok && b < 20);
        bus.key_valid = 1'b0;
        if (!ok) fail_now("key_accept_timeout");
    endtask

    task automatic drain(input int budget);
        int b;
        b = 0;
        while (sb.size() != 0 && b < budget) begin
            tick();
            b++;
        end
        if (sb.size() != 0) begin
            fail_now("drain_timeout");
            sb.delete();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_key_ready"},    bus.key_ready, 0);
        chk({tag, "_subkey_valid"}, bus.subkey_valid, 0);
        chk({tag, "_subkey"},       bus.subkey, 0);
        chk({tag, "_round"},        bus.subkey_round, 0);
        chk({tag, "_done"},         bus.done, 0);
        chk({tag, "_parity_err"},   bus.parity_err, 0);
    endtask

    // Monitor: a beat seen valid&&ready at the falling edge is consumed at
    // the next rising edge
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            chk("ready_and_valid_exclusive", bus.key_ready & bus.subkey_valid, 0);
            if (bus.subkey_valid) begin
                if (stalled) begin
                    chk("hold_subkey", bus.subkey, hold_sk);
                    chk("hold_round", bus.subkey_round, hold_rnd);
                end
                if (bus.subkey_ready) begin
                    stalled = 1'b0;
                    if (sb.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        e_mon = sb.pop_front();
                        chk("subkey", bus.subkey, e_mon.sk);
                        chk("subkey_round", bus.subkey_round, e_mon.rnd);
                        chk("done", bus.done, e_mon.last);
                        if (bus.done) n_done++;
                    end
                end else begin
                    stalled  = 1'b1;
                    hold_sk  = bus.subkey;
                    hold_rnd = bus.subkey_round;
                    chk("done_while_stalled", bus.done, 0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        bus.key_valid    = 1'b0;
        bus.key_in       = '0;
        bus.decrypt      = 1'b0;
        bus.subkey_ready = 1'b0;
        rst              = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");

        // key_ready rises one clock after release
        rst = 1'b0;
        @(negedge clk);
        chk("key_ready_before_edge", bus.key_ready, 0);
        tick();
        chk("key_ready_after_edge", bus.key_ready, 1);

        // Encrypt, no stalls
        bus.subkey_ready = 1'b1;
        push_run(KEY1, 1'b0);
        send_key(KEY1, 1'b0);
        chk("enc_first_valid", bus.subkey_valid, 1);
        chk("enc_first_subkey", bus.subkey, 48'h1B02EFFC7072);
        chk("enc_parity_ok", bus.parity_err, 0);
        drain(40);
        chk("enc_done_count", n_done, 1);

        // Decrypt, no stalls
        push_run(KEY1, 1'b1);
        send_key(KEY1, 1'b1);
        chk("dec_first_subkey", bus.subkey, 48'hCB3D8B0E17F5);
        chk("dec_first_round", bus.subkey_round, 15);
        drain(40);
        chk("dec_done_count", n_done, 2);

        // Random stalls with stray key_valid pulses during RUN
        push_run(KEY1, 1'b0);
        send_key(KEY1, 1'b0);
        b = 0;
        while (sb.size() != 0 && b < 400) begin
            bus.subkey_ready = 1'($urandom_range(0, 1));
            bus.key_valid    = ($urandom_range(0, 3) == 0);
            bus.key_in       = {$urandom, $urandom};
            bus.decrypt      = 1'($urandom_range(0, 1));
            tick();
            b++;
        end
        bus.key_valid    = 1'b0;
        bus.subkey_ready = 1'b1;
        if (sb.size() != 0) begin
            fail_now("stall_run_timeout");
            sb.delete();
        end
        chk("stall_done_count", n_done, 3);
        chk("stall_back_idle", bus.key_ready, 1);

        // Reset in the middle of beat 7
        push_run(KEY1, 1'b0);
        send_key(KEY1, 1'b0);
        b = 0;
        while (bus.subkey_round != 4'd6 && b < 20) begin
            tick();
            b++;
        end
        chk("reached_beat7", bus.subkey_round, 6);
        rst = 1'b1;
        sb.delete();
        #1;
        chk_reset_vals("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_run(KEY2, 1'b0);
        send_key(KEY2, 1'b0);
        chk("restart_round", bus.subkey_round, 0);
        chk("restart_subkey", bus.subkey, ref_subkey(KEY2, 1));
        drain(40);
        chk("restart_done_count", n_done, 4);

        // Even-parity key: flag depends on the build, schedule unchanged
        push_run(KEY1P, 1'b0);
        send_key(KEY1P, 1'b0);
        chk("parity_bad_key", bus.parity_err, EXP_PAR_BAD);
        drain(40);
        chk("parity_done_count", n_done, 5);

        // Back-to-back keys with key_valid held high
        push_run(KEY1, 1'b0);
        push_run(KEY2, 1'b1);
        bus.key_in    = KEY1;
        bus.decrypt   = 1'b0;
        bus.key_valid = 1'b1;
        tick();
        bus.key_in    = KEY2;
        bus.decrypt   = 1'b1;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!bus.done && b < 40);
        if (!bus.done) fail_now("b2b_done_timeout");
        tick();
        chk("b2b_key_ready", bus.key_ready, 1);
        chk("b2b_gap_valid", bus.subkey_valid, 0);
        chk("b2b_parity_cleared", bus.parity_err, 0);
        tick();
        bus.key_valid = 1'b0;
        chk("b2b_second_valid", bus.subkey_valid, 1);
        chk("b2b_second_round", bus.subkey_round, 15);
        drain(40);
        chk("b2b_done_count", n_done, 7);
        chk("b2b_parity_ok", bus.parity_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
